// File: rtl/commit_monitor_pkg.sv
// Shared types and constants for the retire-stage commit monitor.
package commit_monitor_pkg;

    // Halt cause codes as seen on halt_code.
    typedef enum logic [1:0] {
        HALT_NONE    = 2'b00,
        HALT_TOHOST  = 2'b01,
        HALT_LOOP    = 2'b10,
        HALT_TIMEOUT = 2'b11
    } halt_code_e;

    // Monitor run state; HALTED is terminal until reset.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } mon_state_e;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
    localparam int unsigned RD_W                = 5;

    // Trace entry is {pc, rd, data}.
    function automatic int unsigned trace_entry_w(input int unsigned xlen);
        return (2 * xlen) + RD_W;
    endfunction

endpackage

// File: rtl/commit_monitor_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags, accepted handshakes and head-of-queue read.
    always_comb begin
        empty_o   = (wr_ptr_q == rd_ptr_q);
        full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop_ok_s  = pop_i && !empty_o;
        push_ok_s = push_i && (!full_o || pop_ok_s);
        rdata_o   = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // Storage and pointer update; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
                wr_ptr_q                   <= wr_ptr_q + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Retire-stage observer: performance counters, program-end detection
// (tohost store, self-loop, watchdog) and a ready/valid retire trace.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH       = 16,
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     LOOP_LIMIT  = 8,
    parameter int unsigned     TIMEOUT     = 100000,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wb_valid_i,
    input  logic [XLEN-1:0]  wb_pc_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             mem_wen_i,
    input  logic [XLEN-1:0]  mem_addr_i,
    input  logic [XLEN-1:0]  mem_wdata_i,
    input  logic             trace_ready_i,
    output logic             trace_valid_o,
    output logic [XLEN-1:0]  trace_pc_o,
    output logic [4:0]       trace_rd_o,
    output logic [XLEN-1:0]  trace_data_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             halted_o,
    output logic [1:0]       halt_code_o,
    output logic [XLEN-1:0]  exit_value_o,
    output logic             overflow_o
);
    localparam int unsigned ENTRY_W = trace_entry_w(XLEN);
    localparam int unsigned LOOP_W  = $clog2(LOOP_LIMIT + 1);

    mon_state_e        state_q;
    logic              halted_q;
    halt_code_e        halt_code_q;
    halt_code_e        halt_code_d;
    logic [XLEN-1:0]   exit_value_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  cycle_cnt_q,  cycle_cnt_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;
    logic [LOOP_W-1:0] loop_run_q,   loop_run_d;
    logic [XLEN-1:0]   last_pc_q,    last_pc_d;

    logic               run_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic               tohost_hit_s;
    logic               loop_hit_s;
    logic               timeout_hit_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_s;

    // Next-state counters, loop run length, halt-cause arbitration and trace entry.
    always_comb begin
        run_s        = (state_q == ST_RUN);
        push_s       = run_s && wb_valid_i;
        pop_s        = !fifo_empty_s && trace_ready_i;
        drop_s       = push_s && fifo_full_s && !pop_s;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        loop_run_d   = loop_run_q;
        last_pc_d    = last_pc_q;
        if (run_s) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (wb_valid_i) begin
                retire_cnt_d = retire_cnt_q + CNT_W'(1);
                last_pc_d    = wb_pc_i;
                // loop_run_q == 0 means no retire seen yet, so reset-value pc never matches.
                if ((loop_run_q != '0) && (wb_pc_i == last_pc_q)) begin
                    loop_run_d = loop_run_q + LOOP_W'(1);
                end else begin
                    loop_run_d = LOOP_W'(1);
                end
            end else begin
                retire_cnt_d = retire_cnt_q;
            end
            if (stall_i) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_i) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end

        tohost_hit_s  = run_s && mem_wen_i && (mem_addr_i == TOHOST_ADDR);
        loop_hit_s    = push_s && (loop_run_d == LOOP_W'(LOOP_LIMIT));
        // The watchdog fires on the edge that brings cycle_cnt to TIMEOUT-1,
        // so the frozen count reads TIMEOUT-1.
        timeout_hit_s = run_s && (cycle_cnt_d == CNT_W'(TIMEOUT - 1));

        if (tohost_hit_s) begin
            halt_code_d = HALT_TOHOST;
        end else if (loop_hit_s) begin
            halt_code_d = HALT_LOOP;
        end else if (timeout_hit_s) begin
            halt_code_d = HALT_TIMEOUT;
        end else begin
            halt_code_d = HALT_NONE;
        end

        entry_s = {wb_pc_i,
                   (wb_we_i ? wb_rd_i   : 5'd0),
                   (wb_we_i ? wb_data_i : {XLEN{1'b0}})};
    end

    // Halt FSM with counters, loop tracker and sticky status registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_RUN;
            halted_q     <= 1'b0;
            halt_code_q  <= HALT_NONE;
            exit_value_q <= '0;
            overflow_q   <= 1'b0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            loop_run_q   <= '0;
            last_pc_q    <= '0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            loop_run_q   <= loop_run_d;
            last_pc_q    <= last_pc_d;
            overflow_q   <= overflow_q | drop_s;
            case (state_q)
                ST_RUN: begin
                    if (halt_code_d != HALT_NONE) begin
                        state_q     <= ST_HALTED;
                        halted_q    <= 1'b1;
                        halt_code_q <= halt_code_d;
                        if (tohost_hit_s) begin
                            exit_value_q <= mem_wdata_i;
                        end
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q  <= ST_HALTED;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk_i   (clk_i),
        .rst_ni  (reset_ni),
        .push_i  (push_s),
        .wdata_i (entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign trace_valid_o = !fifo_empty_s;
    assign trace_pc_o    = head_s[ENTRY_W-1 -: XLEN];
    assign trace_rd_o    = head_s[XLEN +: 5];
    assign trace_data_o  = head_s[XLEN-1:0];
    assign cycle_cnt_o   = cycle_cnt_q;
    assign retire_cnt_o  = retire_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign halted_o      = halted_q;
    assign halt_code_o   = halt_code_q;
    assign exit_value_o  = exit_value_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed self-checking bench for commit_monitor (DEPTH=4, TIMEOUT=50).
module tb_commit_monitor;
    localparam int XLEN       = 32;
    localparam int DEPTH      = 4;
    localparam int CNT_W      = 32;
    localparam int LOOP_LIMIT = 8;
    localparam int TIMEOUT    = 50;

    logic             clk;
    logic             reset_n;
    logic             wb_valid;
    logic [XLEN-1:0]  wb_pc;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             stall;
    logic             flush;
    logic             mem_wen;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic             trace_ready;
    logic             trace_valid;
    logic [XLEN-1:0]  trace_pc;
    logic [4:0]       trace_rd;
    logic [XLEN-1:0]  trace_data;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             halted;
    logic [1:0]       halt_code;
    logic [XLEN-1:0]  exit_value;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] popped_pc[$];

    commit_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .LOOP_LIMIT(LOOP_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .wb_valid_i(wb_valid), .wb_pc_i(wb_pc), .wb_we_i(wb_we),
        .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .stall_i(stall), .flush_i(flush),
        .mem_wen_i(mem_wen), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .trace_ready_i(trace_ready), .trace_valid_o(trace_valid),
        .trace_pc_o(trace_pc), .trace_rd_o(trace_rd), .trace_data_o(trace_data),
        .cycle_cnt_o(cycle_cnt), .retire_cnt_o(retire_cnt),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
        .halted_o(halted), .halt_code_o(halt_code),
        .exit_value_o(exit_value), .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at time %0t, limit 200000", $time);
        $fatal(1, "global timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; record any pop the edge will perform; sample 1 time unit after.
    task automatic step();
        if (trace_valid && trace_ready) popped_pc.push_back(trace_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_pc = '0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
        stall = 1'b0; flush = 1'b0;
        mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
        trace_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic st, input logic fl);
        wb_valid = 1'b1; wb_pc = pc; wb_we = we; wb_rd = rd; wb_data = data;
        stall = st; flush = fl;
        step();
        wb_valid = 1'b0; wb_we = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc,
                             input logic [4:0] rd, input logic [31:0] data);
        check_eq({tag, "_valid"}, 64'(trace_valid), 64'd1);
        check_eq({tag, "_pc"},    64'(trace_pc),    64'(pc));
        check_eq({tag, "_rd"},    64'(trace_rd),    64'(rd));
        check_eq({tag, "_data"},  64'(trace_data),  64'(data));
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        for (int k = 0; k < 60 && cycle_cnt != CNT_W'(n); k++) step();
        check_eq("wait_cycle", 64'(cycle_cnt), 64'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"},  64'(trace_valid), 64'd0);
        check_eq({tag, "_pc"},     64'(trace_pc),    64'd0);
        check_eq({tag, "_rd"},     64'(trace_rd),    64'd0);
        check_eq({tag, "_data"},   64'(trace_data),  64'd0);
        check_eq({tag, "_cycle"},  64'(cycle_cnt),   64'd0);
        check_eq({tag, "_retire"}, 64'(retire_cnt),  64'd0);
        check_eq({tag, "_stall"},  64'(stall_cnt),   64'd0);
        check_eq({tag, "_flush"},  64'(flush_cnt),   64'd0);
        check_eq({tag, "_halted"}, 64'(halted),      64'd0);
        check_eq({tag, "_code"},   64'(halt_code),   64'd0);
        check_eq({tag, "_exit"},   64'(exit_value),  64'd0);
        check_eq({tag, "_ovf"},    64'(overflow),    64'd0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #12;
        check_all_zero("por");
        do_reset();

        // 1: reset mid-run with entries queued and overflow set
        for (int i = 0; i < 5; i++) retire(32'h100 + 32'(4 * i), 1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
        check_eq("t1_valid_before", 64'(trace_valid), 64'd1);
        check_eq("t1_ovf_before", 64'(overflow), 64'd1);
        check_eq("t1_retire_before", 64'(retire_cnt), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t1_async");
        do_reset();

        // 2: non-tohost store ignored, tohost store at cycle 20 halts
        wait_cycle(10);
        mem_wen = 1'b1; mem_addr = 32'h1004; mem_wdata = 32'd99;
        step();
        mem_wen = 1'b0;
        check_eq("t2_other_store_halted", 64'(halted), 64'd0);
        wait_cycle(20);
        mem_wen = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'd42;
        step();
        mem_wen = 1'b0;
        check_eq("t2_halted", 64'(halted), 64'd1);
        check_eq("t2_code", 64'(halt_code), 64'd1);
        check_eq("t2_exit", 64'(exit_value), 64'd42);
        check_eq("t2_cycle", 64'(cycle_cnt), 64'd21);
        for (int i = 0; i < 3; i++) step();
        check_eq("t2_cycle_frozen", 64'(cycle_cnt), 64'd21);
        check_eq("t2_still_halted", 64'(halted), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t2_reset_halted", 64'(halted), 64'd0);
        check_eq("t2_reset_code", 64'(halt_code), 64'd0);
        check_eq("t2_reset_exit", 64'(exit_value), 64'd0);
        do_reset();

        // 3a: 8 retires at 0x40 with bubbles -> self-loop halt
        trace_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            retire(32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
            step();
        end
        check_eq("t3_no_halt_at7", 64'(halted), 64'd0);
        check_eq("t3_retire7", 64'(retire_cnt), 64'd7);
        retire(32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_eq("t3_halted", 64'(halted), 64'd1);
        check_eq("t3_code", 64'(halt_code), 64'd2);
        check_eq("t3_retire8", 64'(retire_cnt), 64'd8);
        check_eq("t3_exit", 64'(exit_value), 64'd0);
        retire(32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_eq("t3_retire_frozen", 64'(retire_cnt), 64'd8);
        do_reset();

        // 3b: 7 at 0x40 then 0x44 -> no halt
        trace_ready = 1'b1;
        for (int i = 0; i < 7; i++) retire(32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        retire(32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        retire(32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        step();
        check_eq("t3b_no_halt", 64'(halted), 64'd0);
        check_eq("t3b_code", 64'(halt_code), 64'd0);
        do_reset();

        // 4a: watchdog
        for (int k = 0; k < 60 && !halted; k++) step();
        check_eq("t4_halted", 64'(halted), 64'd1);
        check_eq("t4_code", 64'(halt_code), 64'd3);
        check_eq("t4_cycle", 64'(cycle_cnt), 64'd49);
        for (int i = 0; i < 3; i++) step();
        check_eq("t4_cycle_frozen", 64'(cycle_cnt), 64'd49);
        do_reset();

        // 4b: tohost and self-loop in the same cycle -> tohost wins
        trace_ready = 1'b1;
        for (int i = 0; i < 7; i++) retire(32'h80, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_eq("t4b_no_halt", 64'(halted), 64'd0);
        mem_wen = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'd7;
        retire(32'h80, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        mem_wen = 1'b0;
        check_eq("t4b_code", 64'(halt_code), 64'd1);
        check_eq("t4b_exit", 64'(exit_value), 64'd7);
        check_eq("t4b_halted", 64'(halted), 64'd1);
        do_reset();

        // 5a: 6 retires into DEPTH=4 with no ready -> first 4 kept, overflow
        for (int i = 0; i < 6; i++)
            retire(32'h200 + 32'(4 * i), (i != 2), 5'(i + 1), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        check_eq("t5_ovf", 64'(overflow), 64'd1);
        check_eq("t5_retire", 64'(retire_cnt), 64'd6);
        step();
        step();
        check_eq("t5_stable_pc", 64'(trace_pc), 64'h200);
        for (int i = 0; i < 4; i++)
            pop_check($sformatf("t5_e%0d", i), 32'h200 + 32'(4 * i),
                      (i == 2) ? 5'd0 : 5'(i + 1),
                      (i == 2) ? 32'h0 : 32'h1000_0000 + 32'(i));
        check_eq("t5_empty", 64'(trace_valid), 64'd0);
        do_reset();

        // 5b: push while full with a simultaneous pop -> no drop
        for (int i = 0; i < 4; i++) retire(32'h300 + 32'(4 * i), 1'b1, 5'd9, 32'(i), 1'b0, 1'b0);
        check_eq("t5b_ovf_full", 64'(overflow), 64'd0);
        trace_ready = 1'b1;
        retire(32'h310, 1'b1, 5'd9, 32'd4, 1'b0, 1'b0);
        trace_ready = 1'b0;
        check_eq("t5b_ovf_after", 64'(overflow), 64'd0);
        for (int i = 1; i < 5; i++)
            pop_check($sformatf("t5b_e%0d", i), 32'h300 + 32'(4 * i), 5'd9, 32'(i));
        check_eq("t5b_empty", 64'(trace_valid), 64'd0);
        do_reset();

        // 6: stalls, flushes and 10 retires with continuous draining
        trace_ready = 1'b1;
        popped_pc.delete();
        retire(32'h400, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0);
        retire(32'h404, 1'b1, 5'd2, 32'h2, 1'b0, 1'b0);
        stall = 1'b1; step(); step(); stall = 1'b0;
        retire(32'h408, 1'b1, 5'd3, 32'h3, 1'b0, 1'b0);
        flush = 1'b1; step(); flush = 1'b0;
        retire(32'h40C, 1'b1, 5'd4, 32'h4, 1'b0, 1'b0);
        retire(32'h410, 1'b1, 5'd5, 32'h5, 1'b1, 1'b0);
        retire(32'h414, 1'b1, 5'd6, 32'h6, 1'b0, 1'b0);
        retire(32'h418, 1'b1, 5'd7, 32'h7, 1'b0, 1'b1);
        retire(32'h41C, 1'b1, 5'd8, 32'h8, 1'b0, 1'b0);
        retire(32'h420, 1'b1, 5'd9, 32'h9, 1'b0, 1'b0);
        retire(32'h424, 1'b1, 5'd10, 32'hA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check_eq("t6_stall", 64'(stall_cnt), 64'd3);
        check_eq("t6_flush", 64'(flush_cnt), 64'd2);
        check_eq("t6_retire", 64'(retire_cnt), 64'd10);
        check_eq("t6_cycle", 64'(cycle_cnt), 64'd16);
        check_eq("t6_ovf", 64'(overflow), 64'd0);
        check_eq("t6_pops", 64'(popped_pc.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < popped_pc.size())
                check_eq($sformatf("t6_order%0d", i), 64'(popped_pc[i]), 64'(32'h400 + 32'(4 * i)));
        end
        check_eq("t6_drained", 64'(trace_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
